// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - four-requester round-robin arbiter driving a shared 4:1 data channel
//
// Purpose:
//   Grants one of four requesters ownership of a shared output channel. The
//   arbiter picks a winner in round-robin order starting at an internal
//   pointer. It keeps the grant until one of three things happens: the owner
//   ends its burst, the owner reaches the beat limit, or the owner drops its
//   request. Every handoff passes through exactly one IDLE cycle.
//
// Ports:
//   clk        in   system clock, rising-edge active
//   rst_n      in   asynchronous active-low reset
//   req        in   [3:0]      per-requester request
//   data       in   [4*DW-1:0] requester data lanes, lane i at [i*DW +: DW]
//   last       in   [3:0]      per-requester end-of-burst flag
//   out_ready  in   downstream ready
//   out_valid  out  shared channel holds a valid beat
//   out_data   out  [DW-1:0]   data of the owning lane (zero when idle)
//   grant      out  [3:0]      one-hot owner, zero when idle
//   sel        out  [1:0]      index of the current or most recent owner
//   busy       out  high while a requester owns the channel

`timescale 1ns/1ps

module rr_mux_arbiter #(
  parameter int DW        = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] data,
  input  logic [3:0]      last,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [3:0]      grant,
  output logic [1:0]      sel,
  output logic            busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Beat counter value at which the next transfer is the final one allowed.
  localparam logic [3:0] LAST_BEAT = 4'(MAX_BEATS - 1);

  state_t     state_q, state_d;
  logic [1:0] ptr_q,   ptr_d;
  logic [1:0] sel_q,   sel_d;
  logic [3:0] cnt_q,   cnt_d;

  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] cand;
  logic       owner_req;
  logic       xfer;
  logic       burst_end;

  // Round-robin winner: the first set request bit scanning ptr, ptr+1, ...
  // The 2-bit addition wraps 3 -> 0 on its own.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Only the owner's lane matters while granted; the other requesters are
  // ignored until the next arbitration.
  always_comb begin
    owner_req = req[sel_q];
    xfer      = (state_q == GRANT) && owner_req && out_ready;
    // A last flag and the beat limit in the same cycle are still one release.
    burst_end = last[sel_q] || (cnt_q == LAST_BEAT);
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          sel_d   = win_idx;
          cnt_d   = 4'd0;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          // Abort: the owner withdrew, no beat moves this cycle.
          state_d = IDLE;
          ptr_d   = sel_q + 2'd1;
        end else if (xfer) begin
          cnt_d = cnt_q + 4'd1;
          if (burst_end) begin
            state_d = IDLE;
            ptr_d   = sel_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are decoded from registered state, so an asynchronous reset
  // clears them immediately without waiting for a clock edge.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    grant     = 4'd0;
    busy      = 1'b0;
    if (state_q == GRANT) begin
      out_valid = owner_req;
      out_data  = data[sel_q*DW +: DW];
      grant     = 4'b0001 << sel_q;
      busy      = 1'b1;
    end
  end

  assign sel = sel_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - scoreboard testbench for rr_mux_arbiter

`timescale 1ns/1ps

module tb_rr_mux_arbiter;

  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      req;
  logic [4*DW-1:0] data;
  logic [3:0]      last;
  logic            out_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [3:0]      grant;
  logic [1:0]      sel;
  logic            busy;

  int vectors = 0;
  int errors  = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_v;

  rr_mux_arbiter #(.DW(DW), .MAX_BEATS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data      (data),
    .last      (last),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .grant     (grant),
    .sel       (sel),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_lane(input int idx, input logic [DW-1:0] v);
    data[idx*DW +: DW] = v;
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; req = 4'b1111; last = 4'b0000; out_ready = 1'b1;
    data = {8'h44, 8'h33, 8'h22, 8'h11};
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    vectors++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", out_data); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", sel); end
    step();
    rst_n = 1'b1; req = 4'b0000;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    step();
  endtask

  // All four requesting with single-beat bursts: owners 0,1,2,3,0 with one
  // IDLE cycle between each grant.
  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    int own_q[$];
    int own;
    for (int i = 0; i < 4; i++) set_lane(i, DW'(8'h10 + i));
    req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      own_q.push_back(order[i]);
      exp_q.push_back(DW'(8'h10 + order[i]));
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vectors++;
      if (busy !== c[0]) begin errors++; $display("FAIL rr_busy_c%0d: got %b expected %b", c, busy, c[0]); end
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0 || own_q.size() == 0) begin
          errors++; $display("FAIL rr_underflow: got extra beat %h expected none", out_data);
        end else begin
          exp_v = exp_q.pop_front();
          own = own_q.pop_front();
          if (out_data !== exp_v) begin errors++; $display("FAIL rr_data: got %h expected %h", out_data, exp_v); end
          vectors++;
          if (grant !== (4'b0001 << own)) begin errors++; $display("FAIL rr_grant: got %b expected owner %0d", grant, own); end
          vectors++;
          if (sel !== 2'(own)) begin errors++; $display("FAIL rr_sel: got %0d expected %0d", sel, own); end
        end
      end
      step();
    end
    req = 4'b0000;
    vectors++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rr_leftover: got %0d pending expected 0", exp_q.size()); exp_q.delete(); end
    step();
  endtask

  // Requester 2 alone, three beats of 8'hA5, last on the third.
  task automatic test_single_burst();
    int beats = 0;
    set_lane(2, 8'hA5);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(8'hA5);
    for (int c = 0; c < 8; c++) begin
      req  = (beats < 3) ? 4'b0100 : 4'b0000;
      last = (beats == 2) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      if (out_valid && out_ready) begin
        beats++;
        vectors++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL burst_underflow: got extra beat %h expected none", out_data);
        end else begin
          exp_v = exp_q.pop_front();
          if (out_data !== exp_v) begin errors++; $display("FAIL burst_data: got %h expected %h", out_data, exp_v); end
        end
        vectors++;
        if (sel !== 2'd2) begin errors++; $display("FAIL burst_sel: got %0d expected 2", sel); end
      end
      step();
    end
    vectors++; if (beats != 3) begin errors++; $display("FAIL burst_count: got %0d expected 3", beats); end
    vectors++; if (dut.ptr_q !== 2'd3) begin errors++; $display("FAIL burst_ptr: got %0d expected 3", dut.ptr_q); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL burst_busy_end: got %b expected 0", busy); end
    vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL burst_leftover: got %0d expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  // Requester 1 holds req with no last: 16 beats, forced release, one IDLE
  // cycle, re-grant to 1, then an abort.
  task automatic test_max_beats();
    int  xfers = 0;
    logic exp_busy;
    last = 4'b0000; out_ready = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      set_lane(1, DW'(c));
      req = (c <= 18) ? 4'b0010 : 4'b0000;
      exp_busy = (c >= 1 && c <= 16) || c == 18 || c == 19;
      if ((c >= 1 && c <= 16) || c == 18) exp_q.push_back(DW'(c));
      @(negedge clk);
      vectors++;
      if (busy !== exp_busy) begin errors++; $display("FAIL max_busy_c%0d: got %b expected %b", c, busy, exp_busy); end
      if (out_valid && out_ready) begin
        xfers++;
        vectors++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL max_underflow: got extra beat %h expected none", out_data);
        end else begin
          exp_v = exp_q.pop_front();
          if (out_data !== exp_v) begin errors++; $display("FAIL max_data: got %h expected %h", out_data, exp_v); end
        end
      end
      if (c == 18) begin
        vectors++;
        if (grant !== 4'b0010) begin errors++; $display("FAIL max_regrant: got %b expected 0010", grant); end
      end
      step();
    end
    vectors++; if (xfers != 17) begin errors++; $display("FAIL max_xfers: got %0d expected 17", xfers); end
    vectors++; if (dut.ptr_q !== 2'd2) begin errors++; $display("FAIL max_ptr: got %0d expected 2", dut.ptr_q); end
    vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL max_leftover: got %0d expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  // Owner 3 stalled by out_ready low for 10 cycles while non-owners churn,
  // then req[3] drops.
  task automatic test_stall_abort();
    int xfers = 0;
    out_ready = 1'b0; last = 4'b0111;
    for (int c = 0; c <= 12; c++) begin
      data = {$urandom, $urandom};
      set_lane(3, 8'hC3);
      req = (c <= 10) ? ((c >= 3) ? 4'b1001 : 4'b1000) : 4'b0000;
      @(negedge clk);
      if (out_valid && out_ready) xfers++;
      if (c == 0) begin
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_idle: got %b expected 0", busy); end
      end else if (c <= 10) begin
        vectors++; if (grant !== 4'b1000) begin errors++; $display("FAIL stall_grant_c%0d: got %b expected 1000", c, grant); end
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid_c%0d: got %b expected 1", c, out_valid); end
        vectors++; if (out_data !== 8'hC3) begin errors++; $display("FAIL stall_data_c%0d: got %h expected c3", c, out_data); end
      end else if (c == 11) begin
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b expected 0", out_valid); end
        vectors++; if (dut.cnt_q !== 4'd0) begin errors++; $display("FAIL stall_cnt: got %0d expected 0", dut.cnt_q); end
      end else begin
        vectors++; if (grant !== 4'b0000) begin errors++; $display("FAIL abort_grant: got %b expected 0000", grant); end
        vectors++; if (dut.ptr_q !== 2'd0) begin errors++; $display("FAIL abort_ptr: got %0d expected 0", dut.ptr_q); end
      end
      step();
    end
    vectors++; if (xfers != 0) begin errors++; $display("FAIL stall_xfers: got %0d expected 0", xfers); end
    out_ready = 1'b1; last = 4'b0000;
  endtask

  // Drive ptr to 3 through a one-beat burst from requester 2, then
  // req=0011 must wrap to requester 0 ahead of requester 1.
  task automatic test_wrap();
    data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    out_ready = 1'b1;
    exp_q.push_back(8'hD2);
    exp_q.push_back(8'hD0);
    for (int c = 0; c < 6; c++) begin
      case (c)
        0, 1:    begin req = 4'b0100; last = 4'b0100; end
        3, 4:    begin req = 4'b0011; last = 4'b0001; end
        default: begin req = 4'b0000; last = 4'b0000; end
      endcase
      @(negedge clk);
      if (c == 3) begin
        vectors++; if (dut.ptr_q !== 2'd3) begin errors++; $display("FAIL wrap_ptr_pre: got %0d expected 3", dut.ptr_q); end
      end
      if (c == 4) begin
        vectors++; if (grant !== 4'b0001) begin errors++; $display("FAIL wrap_grant: got %b expected 0001", grant); end
        vectors++; if (sel !== 2'd0) begin errors++; $display("FAIL wrap_sel: got %0d expected 0", sel); end
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL wrap_underflow: got extra beat %h expected none", out_data);
        end else begin
          exp_v = exp_q.pop_front();
          if (out_data !== exp_v) begin errors++; $display("FAIL wrap_data: got %h expected %h", out_data, exp_v); end
        end
      end
      step();
    end
    vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_leftover: got %0d expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  // Reset pulsed mid-burst of requester 2; after release, req=0110 must go
  // to requester 1 because the pointer restarts at 0.
  task automatic test_reset_mid_burst();
    set_lane(2, 8'h5A);
    set_lane(1, 8'h77);
    req = 4'b0100; last = 4'b0000; out_ready = 1'b1;
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h5A);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rstmid_underflow: got extra beat %h expected none", out_data);
        end else begin
          exp_v = exp_q.pop_front();
          if (out_data !== exp_v) begin errors++; $display("FAIL rstmid_data: got %h expected %h", out_data, exp_v); end
        end
      end
      step();
    end
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_preburst: got %b expected 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (grant !== 4'b0000) begin errors++; $display("FAIL rstmid_grant_async: got %b expected 0000", grant); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid_async: got %b expected 0", out_valid); end
    vectors++; if (out_data !== 8'h00) begin errors++; $display("FAIL rstmid_data_async: got %h expected 00", out_data); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_async: got %b expected 0", busy); end
    req = 4'b0110;
    step();
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid_held: got %b expected 0", out_valid); end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle_after: got %b expected 0", busy); end
    step();
    @(negedge clk);
    vectors++; if (grant !== 4'b0010) begin errors++; $display("FAIL rstmid_first_grant: got %b expected 0010", grant); end
    vectors++; if (out_data !== 8'h77) begin errors++; $display("FAIL rstmid_first_data: got %h expected 77", out_data); end
    step();
    req = 4'b0000;
    step();
    step();
    vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL rstmid_leftover: got %0d expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_burst();
    test_max_beats();
    test_stall_abort();
    test_wrap();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
